uart_cmd_frame_tx: RTL and testbench
====================================

// Module: uart_cmd_frame_tx
// PURPOSE
//  Builds and transmits the 8-byte LED command frame: 55 A5 T3 T2 T1 T0 CTRL F0.
//  Snapshots led_ctrl/led_time_set on a send request and feeds bytes one at a time
//  to the UART byte transmitter via a tx_start/tx_done handshake.
//  Sits between host-side control logic and the UART byte TX; it is the sending end
//  of the LED command link.
// PARAMETERS
//  HEAD0        8'h55   frame byte 0
//  HEAD1        8'hA5   frame byte 1
//  TAIL         8'hF0   frame byte 7
//  GAP_CYC      0       idle Clk cycles inserted between tx_done and next tx_start (0..65535)
//  TIMEOUT_CYC  1000000 max Clk cycles waiting for tx_done before abort (>=2)
// PORTS
//  Clk           in   1   system clock
//  Reset_n       in   1   asynchronous, active-low reset
//  send_en       in   1   1-cycle request to send one frame
//  led_ctrl      in   8   payload, frame byte 6
//  led_time_set  in   32  payload, bytes 2..5 MSB first
//  tx_done       in   1   1-cycle pulse from byte TX: current byte finished
//  tx_data       out  8   byte to byte TX
//  tx_start      out  1   1-cycle pulse: byte TX begins sending tx_data
//  busy          out  1   high while a frame is in progress
//  frame_done    out  1   1-cycle pulse: all 8 bytes acknowledged
//  frame_err     out  1   1-cycle pulse: frame aborted on tx_done timeout
// BEHAVIOUR
//  Reset (async): all outputs 0, state IDLE, byte index 0, snapshot regs 0.
//  States: IDLE -> START -> WAIT -> (GAP) -> START ... -> DONE -> IDLE.
//  IDLE: send_en=1 at cycle N -> latch {led_time_set,led_ctrl}, index=0, busy=1 at N+1.
//  START: tx_data=byte[index], tx_start=1 for exactly one cycle (first at N+1); go WAIT.
//  tx_data holds byte[index] stable from the tx_start cycle until the matching tx_done.
//  WAIT: tx_done=1 at cycle M -> if index==7 go DONE; else index+1 and go GAP
//   (GAP_CYC>0) or START (GAP_CYC=0, next tx_start at M+1).
//  GAP: count GAP_CYC cycles, then START; next tx_start at M+1+GAP_CYC.
//  DONE: frame_done=1 for one cycle at M+1; busy=0 in same cycle; state IDLE.
//  Byte map: 0=HEAD0 1=HEAD1 2=T[31:24] 3=T[23:16] 4=T[15:8] 5=T[7:0] 6=CTRL 7=TAIL.
//  Payload is the snapshot; input changes during a frame do not affect it.
//  send_en while busy=1 ignored (not queued); send_en in the frame_done cycle accepted.
//  tx_done outside WAIT (IDLE/GAP/START) ignored.
//  Timeout: counter clears on every tx_start; reaching TIMEOUT_CYC in WAIT -> frame_err=1
//   one cycle, busy=0, state IDLE, no frame_done.
//  Reset mid-frame: immediate abort, outputs to reset values, no done/err pulse.
//  tx_start, frame_done and frame_err never high in the same cycle.
// TESTING
//  1 send_en with ctrl=8'h3C, time=32'h0001_E240, tx_done 20 cycles after each tx_start
//    -> bytes 55 A5 00 01 E2 40 3C F0 in order, 8 tx_start, one frame_done, busy low after.
//  2 send_en pulsed again mid-frame and payload inputs changed -> ignored, frame bytes
//    unchanged, exactly one frame_done.
//  3 GAP_CYC=5, tx_done at M -> next tx_start exactly at M+6; GAP_CYC=0 -> at M+1.
//  4 TIMEOUT_CYC=50, withhold tx_done after byte 3 -> frame_err at 50 cycles, busy=0,
//    no frame_done; next send_en starts fresh at byte 55.
//  5 Reset_n low after byte 4 tx_start -> all outputs 0 immediately; after release a new
//    send_en yields a complete correct frame.
//  6 send_en in frame_done cycle -> second frame starts next cycle, back-to-back intact.

Source files
------------

// File: rtl/uart_cmd_frame_tx.sv
// Sends the 8-byte LED command frame (55 A5 T3 T2 T1 T0 CTRL F0) one byte at a time
// through a UART byte transmitter using a tx_start/tx_done handshake.
//
// state   | meaning
// IDLE    | waiting for send_en
// START   | tx_start pulse for byte[idx]
// WAIT    | waiting for tx_done, timeout counter running
// GAP     | idle spacing before the next byte
// DONE    | frame_done pulse, may accept a new send_en
// ERR     | frame_err pulse after tx_done timeout
module uart_cmd_frame_tx #(
  parameter logic [7:0]  HEAD0       = 8'h55,
  parameter logic [7:0]  HEAD1       = 8'hA5,
  parameter logic [7:0]  TAIL        = 8'hF0,
  parameter int unsigned GAP_CYC     = 0,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        send_en,
  input  logic [7:0]  led_ctrl,
  input  logic [31:0] led_time_set,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  // Wraps when GAP_CYC is 0; the GAP state is never entered in that case.
  localparam logic [15:0]   GAP_LAST = 16'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t         state, state_nxt;
  logic [2:0]     idx;
  logic [31:0]    snap_time;
  logic [7:0]     snap_ctrl;
  logic [TW-1:0]  tmo_cnt;
  logic [15:0]    gap_cnt;
  logic           load;
  logic           adv;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tx_start   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    load       = 1'b0;
    adv        = 1'b0;
    case (state)
      S_IDLE: begin
        if (send_en) begin
          load      = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        tx_start  = 1'b1;
        busy      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (tx_done) begin
          if (idx == 3'd7) begin
            state_nxt = S_DONE;
          end else begin
            adv       = 1'b1;
            state_nxt = (GAP_CYC == 0) ? S_START : S_GAP;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = S_ERR;
        end
      end
      S_GAP: begin
        busy = 1'b1;
        if (gap_cnt == 16'd0) state_nxt = S_START;
      end
      S_DONE: begin
        frame_done = 1'b1;
        // A request landing on the frame_done cycle starts the next frame back-to-back.
        if (send_en) begin
          load      = 1'b1;
          state_nxt = S_START;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ERR: begin
        frame_err = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx       <= 3'd0;
      snap_time <= 32'd0;
      snap_ctrl <= 8'd0;
    end else if (load) begin
      idx       <= 3'd0;
      snap_time <= led_time_set;
      snap_ctrl <= led_ctrl;
    end else if (adv) begin
      idx <= idx + 3'd1;
    end
  end

  // tmo_cnt is 0 in the tx_start cycle and counts cycles since then.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tmo_cnt <= '0;
      gap_cnt <= 16'd0;
    end else begin
      if (state_nxt == S_START)
        tmo_cnt <= '0;
      else if (state == S_START || state == S_WAIT)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (adv)
        gap_cnt <= GAP_LAST;
      else if (state == S_GAP)
        gap_cnt <= gap_cnt - 16'd1;
    end
  end

  always_comb begin
    tx_data = 8'd0;
    if (state == S_START || state == S_WAIT) begin
      case (idx)
        3'd0:    tx_data = HEAD0;
        3'd1:    tx_data = HEAD1;
        3'd2:    tx_data = snap_time[31:24];
        3'd3:    tx_data = snap_time[23:16];
        3'd4:    tx_data = snap_time[15:8];
        3'd5:    tx_data = snap_time[7:0];
        3'd6:    tx_data = snap_ctrl;
        default: tx_data = TAIL;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Bench for uart_cmd_frame_tx: two instances (GAP_CYC 0 and 5, TIMEOUT_CYC 50) driven
// by a shared payload, each with its own tx_done responder and byte monitor.
module tb_uart_cmd_frame_tx;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [7:0]  led_ctrl;
  logic [31:0] led_time_set;
  logic        send_en    [2];
  logic        tx_done    [2] = '{1'b0, 1'b0};
  logic [7:0]  tx_data    [2];
  logic        tx_start   [2];
  logic        busy       [2];
  logic        frame_done [2];
  logic        frame_err  [2];

  uart_cmd_frame_tx #(.GAP_CYC(0), .TIMEOUT_CYC(50)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .send_en(send_en[0]), .led_ctrl(led_ctrl),
    .led_time_set(led_time_set), .tx_done(tx_done[0]), .tx_data(tx_data[0]),
    .tx_start(tx_start[0]), .busy(busy[0]), .frame_done(frame_done[0]),
    .frame_err(frame_err[0])
  );

  uart_cmd_frame_tx #(.GAP_CYC(5), .TIMEOUT_CYC(50)) dut5 (
    .Clk(Clk), .Reset_n(Reset_n), .send_en(send_en[1]), .led_ctrl(led_ctrl),
    .led_time_set(led_time_set), .tx_done(tx_done[1]), .tx_data(tx_data[1]),
    .tx_start(tx_start[1]), .busy(busy[1]), .frame_done(frame_done[1]),
    .frame_err(frame_err[1])
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         resp_delay    = 20;
  int         withhold_from = 8;
  int         cnt       [2] = '{0, 0};
  int         fidx      [2] = '{0, 0};
  int         gcnt      [2] = '{0, 0};
  int         fd_cnt    [2] = '{0, 0};
  int         fe_cnt    [2] = '{0, 0};
  int         fe_cyc    [2] = '{0, 0};
  int         last_done [2] = '{0, 0};
  bit         done_vld  [2] = '{1'b0, 1'b0};
  logic [7:0] cur_byte  [2] = '{8'd0, 8'd0};
  logic [7:0] got_b     [2][16];
  int         start_cyc [2][16];

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 5;
  endfunction

  // Responder answers each tx_start with tx_done resp_delay cycles later (unless withheld);
  // monitor records bytes and checks spacing, pulse exclusivity and data hold.
  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      tx_done[i] = 1'b0;
      if (!Reset_n) begin
        cnt[i]      = 0;
        fidx[i]     = 0;
        done_vld[i] = 1'b0;
      end else begin
        int sum;
        sum = int'(tx_start[i]) + int'(frame_done[i]) + int'(frame_err[i]);
        if (sum > 0) check($sformatf("d%0d_pulse_excl", i), 32'(sum), 32'd1);
        if (tx_start[i]) begin
          if (done_vld[i])
            check($sformatf("d%0d_gap", i), 32'(cyc - last_done[i]), 32'(gap_of(i) + 1));
          if (gcnt[i] < 16) begin
            got_b[i][gcnt[i]]     = tx_data[i];
            start_cyc[i][gcnt[i]] = cyc;
            gcnt[i]++;
          end
          cnt[i]      = (fidx[i] < withhold_from) ? resp_delay : 0;
          cur_byte[i] = tx_data[i];
          fidx[i]++;
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            tx_done[i] = 1'b1;
            check($sformatf("d%0d_data_hold", i), 32'(tx_data[i]), 32'(cur_byte[i]));
            last_done[i] = cyc;
            done_vld[i]  = 1'b1;
          end
        end
        if (frame_done[i]) begin
          fd_cnt[i]++;
          check($sformatf("d%0d_done_busy", i), 32'(busy[i]), 32'd0);
          done_vld[i] = 1'b0;
          fidx[i]     = 0;
        end
        if (frame_err[i]) begin
          fe_cnt[i]++;
          fe_cyc[i] = cyc;
          check($sformatf("d%0d_err_busy", i), 32'(busy[i]), 32'd0);
          done_vld[i] = 1'b0;
          fidx[i]     = 0;
        end
      end
    end
  end

  task automatic clear_stats();
    fd_cnt = '{0, 0};
    fe_cnt = '{0, 0};
    gcnt   = '{0, 0};
  endtask

  task automatic send(input logic [1:0] mask, input logic [7:0] c, input logic [31:0] t);
    @(posedge Clk);
    #1;
    send_en[0]   = mask[0];
    send_en[1]   = mask[1];
    led_ctrl     = c;
    led_time_set = t;
    @(posedge Clk);
    #1;
    send_en[0] = 1'b0;
    send_en[1] = 1'b0;
  endtask

  task automatic wait_fd(input int t0, input int t1, input int budget, input string tag);
    int  n;
    logic ok;
    n = 0;
    while ((fd_cnt[0] < t0 || fd_cnt[1] < t1) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    ok = (fd_cnt[0] >= t0 && fd_cnt[1] >= t1);
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_frame(input int i, input int base, input logic [7:0] c,
                             input logic [31:0] t);
    logic [7:0] exp [8];
    exp = '{8'h55, 8'hA5, t[31:24], t[23:16], t[15:8], t[7:0], c, 8'hF0};
    for (int k = 0; k < 8; k++)
      check($sformatf("d%0d_byte%0d", i, base + k), 32'(got_b[i][base + k]), 32'(exp[k]));
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_d%0d_tx_data", tag, i), 32'(tx_data[i]), 32'd0);
      check($sformatf("%s_d%0d_tx_start", tag, i), 32'(tx_start[i]), 32'd0);
      check($sformatf("%s_d%0d_busy", tag, i), 32'(busy[i]), 32'd0);
      check($sformatf("%s_d%0d_frame_done", tag, i), 32'(frame_done[i]), 32'd0);
      check($sformatf("%s_d%0d_frame_err", tag, i), 32'(frame_err[i]), 32'd0);
    end
  endtask

  initial begin
    Reset_n      = 1'b0;
    send_en[0]   = 1'b0;
    send_en[1]   = 1'b0;
    led_ctrl     = 8'd0;
    led_time_set = 32'd0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_idle_outputs("reset");
    @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Basic frame with start latency check
    clear_stats();
    send(2'b11, 8'h3C, 32'h0001_E240);
    @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t1_d%0d_busy_n1", i), 32'(busy[i]), 32'd1);
      check($sformatf("t1_d%0d_start_n1", i), 32'(tx_start[i]), 32'd1);
    end
    wait_fd(1, 1, 400, "t1_wait_done");
    repeat (3) @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      check_frame(i, 0, 8'h3C, 32'h0001_E240);
      check($sformatf("t1_d%0d_nbytes", i), 32'(gcnt[i]), 32'd8);
      check($sformatf("t1_d%0d_ndone", i), 32'(fd_cnt[i]), 32'd1);
      check($sformatf("t1_d%0d_busy_end", i), 32'(busy[i]), 32'd0);
    end

    // Mid-frame request and payload change are ignored
    clear_stats();
    send(2'b11, 8'hA7, 32'h1234_5678);
    repeat (50) @(posedge Clk);
    send(2'b11, 8'hFF, 32'hFFFF_FFFF);
    wait_fd(1, 1, 400, "t2_wait_done");
    repeat (40) @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      check_frame(i, 0, 8'hA7, 32'h1234_5678);
      check($sformatf("t2_d%0d_nbytes", i), 32'(gcnt[i]), 32'd8);
      check($sformatf("t2_d%0d_ndone", i), 32'(fd_cnt[i]), 32'd1);
    end

    // Timeout on byte index 3
    clear_stats();
    withhold_from = 3;
    send(2'b11, 8'h01, 32'h0203_0405);
    begin
      int n;
      n = 0;
      while ((fe_cnt[0] < 1 || fe_cnt[1] < 1) && n < 400) begin
        @(negedge Clk);
        n++;
      end
    end
    repeat (3) @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t4_d%0d_nerr", i), 32'(fe_cnt[i]), 32'd1);
      check($sformatf("t4_d%0d_tmo_cyc", i), 32'(fe_cyc[i] - start_cyc[i][3]), 32'd50);
      check($sformatf("t4_d%0d_ndone", i), 32'(fd_cnt[i]), 32'd0);
      check($sformatf("t4_d%0d_nbytes", i), 32'(gcnt[i]), 32'd4);
    end
    withhold_from = 8;
    clear_stats();
    send(2'b11, 8'h5E, 32'hCAFE_0042);
    wait_fd(1, 1, 400, "t4_wait_fresh");
    for (int i = 0; i < 2; i++) check_frame(i, 0, 8'h5E, 32'hCAFE_0042);

    // Reset mid-frame, then a clean frame
    repeat (3) @(posedge Clk);
    clear_stats();
    send(2'b11, 8'h5A, 32'hDEAD_BEEF);
    begin
      int n;
      logic ok;
      n = 0;
      while (gcnt[0] < 5 && n < 300) begin
        @(negedge Clk);
        n++;
      end
      ok = (gcnt[0] >= 5);
      check("t5_reach_byte4", 32'(ok), 32'd1);
    end
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check_idle_outputs("t5_rst");
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t5_d%0d_no_done", i), 32'(fd_cnt[i]), 32'd0);
      check($sformatf("t5_d%0d_no_err", i), 32'(fe_cnt[i]), 32'd0);
    end
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    clear_stats();
    send(2'b11, 8'hC3, 32'h89AB_CDEF);
    wait_fd(1, 1, 400, "t5_wait_done");
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      check_frame(i, 0, 8'hC3, 32'h89AB_CDEF);
      check($sformatf("t5_d%0d_nerr", i), 32'(fe_cnt[i]), 32'd0);
    end

    // Request in the frame_done cycle starts the next frame immediately (GAP 0 instance)
    clear_stats();
    send(2'b11, 8'h11, 32'h2233_4455);
    begin
      int n;
      n = 0;
      while (frame_done[0] !== 1'b1 && n < 400) begin
        @(negedge Clk);
        n++;
      end
      check("t6_saw_done", 32'(frame_done[0]), 32'd1);
    end
    send_en[0]   = 1'b1;
    led_ctrl     = 8'h66;
    led_time_set = 32'h7788_99AA;
    @(posedge Clk);
    #1 send_en[0] = 1'b0;
    @(negedge Clk);
    check("t6_b2b_start", 32'(tx_start[0]), 32'd1);
    check("t6_b2b_busy", 32'(busy[0]), 32'd1);
    check("t6_b2b_data", 32'(tx_data[0]), 32'h55);
    wait_fd(2, 1, 500, "t6_wait_done");
    repeat (2) @(negedge Clk);
    check_frame(0, 0, 8'h11, 32'h2233_4455);
    check_frame(0, 8, 8'h66, 32'h7788_99AA);
    check_frame(1, 0, 8'h11, 32'h2233_4455);
    check("t6_d0_nbytes", 32'(gcnt[0]), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected end before limit", cyc);
    $fatal(1, "timeout");
  end

endmodule
